// File: rtl/cdi_bus_pkg.sv
// Shared types and address map for the 68070-side bus arbiter.
package cdi_bus_pkg;

  typedef enum logic [2:0] {
    REG_NONE   = 3'd0,
    REG_MCD212 = 3'd1,
    REG_DVC    = 3'd2,
    REG_CDIC   = 3'd3,
    REG_SLAVE  = 3'd4,
    REG_MK48   = 3'd5,
    REG_BUSERR = 3'd6
  } region_t;

  // Arbiter FSM encoding kept as plain constants so older tools can read the state register.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WAIT    = 3'd1;
  localparam state_t ST_DONE    = 3'd2;
  localparam state_t ST_ERR     = 3'd3;
  localparam state_t ST_RECOVER = 3'd4;

  // Byte-address map (A = {addr, 1'b0}), inclusive bounds.
  localparam logic [23:0] MCD212_LO_LIMIT = 24'h27FFFF;
  localparam logic [23:0] MCD212_HI_BASE  = 24'h400000;
  localparam logic [23:0] MCD212_HI_LIMIT = 24'h4FFFFF;
  localparam logic [23:0] DVC_LO_BASE     = 24'hD00000;
  localparam logic [23:0] DVC_LO_LIMIT    = 24'hDFFFFF;
  localparam logic [23:0] DVC_HI_BASE     = 24'hE80000;
  localparam logic [23:0] DVC_HI_LIMIT    = 24'hEFFFFF;
  localparam logic [23:0] CDIC_BASE       = 24'h300000;
  localparam logic [23:0] CDIC_LIMIT      = 24'h30FFFF;
  localparam logic [23:0] SLAVE_BASE      = 24'h310000;
  localparam logic [23:0] SLAVE_LIMIT     = 24'h31FFFF;
  localparam logic [23:0] MK48_BASE       = 24'h320000;
  localparam logic [23:0] MK48_LIMIT      = 24'h32FFFF;
  localparam logic [23:0] BUSERR_LO_BASE  = 24'h500000;
  localparam logic [23:0] BUSERR_LO_LIMIT = 24'hCFFFFF;
  localparam logic [23:0] BUSERR_HI_BASE  = 24'hF00000;

  // One master's access request as seen by the arbiter.
  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        write;
    logic        uds;
    logic        lds;
  } bus_req_t;

  function automatic logic in_range(input logic [23:0] a, input logic [23:0] lo,
                                    input logic [23:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/cdi_addr_decode.sv
// Combinational address decoder: word address -> target region.
module cdi_addr_decode
  import cdi_bus_pkg::*;
(
  input  logic [22:0] addr,
  output region_t     region
);

  logic [23:0] byte_addr;
  assign byte_addr = {addr, 1'b0};

  // Ranges are disjoint; anything not listed is an unpopulated hole (REG_NONE).
  always_comb begin
    region = REG_NONE;
    if ((byte_addr <= MCD212_LO_LIMIT) ||
        in_range(byte_addr, MCD212_HI_BASE, MCD212_HI_LIMIT))
      region = REG_MCD212;
    else if (in_range(byte_addr, DVC_LO_BASE, DVC_LO_LIMIT) ||
             in_range(byte_addr, DVC_HI_BASE, DVC_HI_LIMIT))
      region = REG_DVC;
    else if (in_range(byte_addr, CDIC_BASE, CDIC_LIMIT))
      region = REG_CDIC;
    else if (in_range(byte_addr, SLAVE_BASE, SLAVE_LIMIT))
      region = REG_SLAVE;
    else if (in_range(byte_addr, MK48_BASE, MK48_LIMIT))
      region = REG_MK48;
    else if (in_range(byte_addr, BUSERR_LO_BASE, BUSERR_LO_LIMIT) ||
             (byte_addr >= BUSERR_HI_BASE))
      region = REG_BUSERR;
  end

endmodule

// File: rtl/cdi_bus_arbiter.sv
// Two-master (CPU m0, CDIC DMA m1) arbiter onto a single slave port with
// watchdog bus-error and a DMA burst limit that guarantees the CPU a slot.
module cdi_bus_arbiter
  import cdi_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DMA_BURST_MAX  = 8
) (
  input  logic        clk30,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [22:0] m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic        m0_write,
  input  logic        m0_uds,
  input  logic        m0_lds,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic [22:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_write,
  input  logic        m1_uds,
  input  logic        m1_lds,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [15:0] m1_rdata,
  output logic        s_valid,
  output region_t     s_region,
  output logic [22:0] s_addr,
  output logic [15:0] s_wdata,
  output logic        s_write,
  output logic        s_uds,
  output logic        s_lds,
  input  logic        s_ack,
  input  logic [15:0] s_rdata,
  output logic        grant_dma
);

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = $clog2(DMA_BURST_MAX + 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(DMA_BURST_MAX);

  state_t        state;
  logic          owner;      // 1 = m1 (DMA) owns the current access
  bus_req_t      req_q;
  region_t       region_q;
  logic [15:0]   rdata_q;
  logic [WW-1:0] wd;
  logic [BW-1:0] burst_cnt;

  bus_req_t m0_bus, m1_bus, sel_bus;
  region_t  sel_region;
  logic     pick_m1;

  assign m0_bus = '{addr: m0_addr, wdata: m0_wdata, write: m0_write, uds: m0_uds, lds: m0_lds};
  assign m1_bus = '{addr: m1_addr, wdata: m1_wdata, write: m1_write, uds: m1_uds, lds: m1_lds};

  // DMA normally wins a tie; once it has taken DMA_BURST_MAX grants past a waiting CPU, the CPU goes.
  assign pick_m1 = m1_req && !(m0_req && (burst_cnt == BURST_LIM));
  assign sel_bus = pick_m1 ? m1_bus : m0_bus;

  cdi_addr_decode u_decode (
    .addr   (sel_bus.addr),
    .region (sel_region)
  );

  // Access sequencer: latch the winner in IDLE, run the slave handshake, report, recover.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      req_q    <= '0;
      region_q <= REG_NONE;
      rdata_q  <= '0;
      wd       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            owner    <= pick_m1;
            req_q    <= sel_bus;
            region_q <= sel_region;
            rdata_q  <= '0;
            wd       <= '0;
            if (sel_region == REG_BUSERR || (!sel_bus.uds && !sel_bus.lds))
              state <= ST_ERR;
            else if (sel_region == REG_NONE)
              state <= ST_DONE;
            else
              state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A completion arriving on the final watchdog cycle still counts as success.
          if (s_ack) begin
            rdata_q <= s_rdata;
            state   <= ST_DONE;
          end else if (wd == WD_LAST) begin
            state <= ST_ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_DONE, ST_ERR: state <= ST_RECOVER;
        ST_RECOVER:      state <= ST_IDLE;
        default:         state <= ST_IDLE;
      endcase
    end
  end

  // Fairness counter: counts DMA grants taken while the CPU was also waiting.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!m0_req)
        burst_cnt <= '0;
      else if (pick_m1) begin
        if (burst_cnt != BURST_LIM)
          burst_cnt <= burst_cnt + 1'b1;
      end else
        burst_cnt <= '0;
    end
  end

  // Slave port is only driven during WAIT so it reads as idle zeros otherwise.
  assign s_valid   = (state == ST_WAIT);
  assign s_region  = s_valid ? region_q : REG_NONE;
  assign s_addr    = s_valid ? req_q.addr : '0;
  assign s_wdata   = s_valid ? req_q.wdata : '0;
  assign s_write   = s_valid & req_q.write;
  assign s_uds     = s_valid & req_q.uds;
  assign s_lds     = s_valid & req_q.lds;
  assign grant_dma = s_valid & owner;

  assign m0_ack   = (state == ST_DONE) && !owner;
  assign m1_ack   = (state == ST_DONE) &&  owner;
  assign m0_err   = (state == ST_ERR)  && !owner;
  assign m1_err   = (state == ST_ERR)  &&  owner;
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_cdi_bus_arbiter.sv
// Self-checking bench for cdi_bus_arbiter with a spec-level reference model.
module tb_cdi_bus_arbiter;
  import cdi_bus_pkg::*;

  localparam int TO = 16;
  localparam int BM = 8;

  logic clk30 = 1'b0;
  logic reset_n = 1'b0;
  logic m0_req = 0, m0_write = 0, m0_uds = 0, m0_lds = 0;
  logic [22:0] m0_addr = '0;
  logic [15:0] m0_wdata = '0;
  logic m1_req = 0, m1_write = 0, m1_uds = 0, m1_lds = 0;
  logic [22:0] m1_addr = '0;
  logic [15:0] m1_wdata = '0;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic s_valid, s_write, s_uds, s_lds, grant_dma;
  region_t s_region;
  logic [22:0] s_addr;
  logic [15:0] s_wdata;
  logic s_ack = 0;
  logic [15:0] s_rdata = '0;

  int checks = 0;
  int failures = 0;

  // observations from run_access
  logic o_ack, o_err, o_after, o_timeout, o_write, o_uds, o_lds;
  logic [15:0] o_rdata, o_wdata;
  logic [22:0] o_addr;
  region_t o_region;
  int o_lat, o_sv, o_other, o_gd_bad;

  cdi_bus_arbiter #(.TIMEOUT_CYCLES(TO), .DMA_BURST_MAX(BM)) dut (
    .clk30(clk30), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_uds(m0_uds), .m0_lds(m0_lds), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_uds(m1_uds), .m1_lds(m1_lds), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_region(s_region), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_write(s_write), .s_uds(s_uds), .s_lds(s_lds), .s_ack(s_ack), .s_rdata(s_rdata),
    .grant_dma(grant_dma)
  );

  always #5 clk30 = ~clk30;

  // Address map straight from the region table, on byte addresses.
  function automatic region_t ref_region(input logic [23:0] a);
    int unsigned x;
    x = a;
    if (x <= 'h27FFFF || (x >= 'h400000 && x <= 'h4FFFFF)) return REG_MCD212;
    if ((x >= 'hD00000 && x <= 'hDFFFFF) || (x >= 'hE80000 && x <= 'hEFFFFF)) return REG_DVC;
    if ((x >> 16) == 'h30) return REG_CDIC;
    if ((x >> 16) == 'h31) return REG_SLAVE;
    if ((x >> 16) == 'h32) return REG_MK48;
    if ((x >= 'h500000 && x <= 'hCFFFFF) || x >= 'hF00000) return REG_BUSERR;
    return REG_NONE;
  endfunction

  function automatic logic [66:0] all_outs();
    return {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, s_valid, s_region,
            s_wdata, s_write, s_uds, s_lds, grant_dma};
  endfunction

  task automatic set_req(input int m, input logic r, input logic [22:0] a, input logic [15:0] d,
                         input logic w, input logic u, input logic l);
    if (m == 0) begin
      m0_req = r; m0_addr = a; m0_wdata = d; m0_write = w; m0_uds = u; m0_lds = l;
    end else begin
      m1_req = r; m1_addr = a; m1_wdata = d; m1_write = w; m1_uds = u; m1_lds = l;
    end
  endtask

  // Drives one access from master m; the slave acks on s_valid cycle dly+1.
  task automatic run_access(input int m, input logic [23:0] ba, input logic [15:0] d,
                            input logic w, input logic u, input logic l, input int dly,
                            input logic [15:0] rd);
    logic own_ack, own_err;
    @(negedge clk30);
    set_req(m, 1'b1, ba[23:1], d, w, u, l);
    o_ack = 0; o_err = 0; o_after = 0; o_timeout = 1; o_rdata = '0; o_lat = 0; o_sv = 0;
    o_other = 0; o_gd_bad = 0; o_region = REG_NONE; o_addr = '0; o_wdata = '0;
    o_write = 0; o_uds = 0; o_lds = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk30);
      if (s_valid) begin
        if (o_sv == 0) begin
          o_region = s_region; o_addr = s_addr; o_wdata = s_wdata;
          o_write = s_write; o_uds = s_uds; o_lds = s_lds;
        end
        if (grant_dma !== (m == 1)) o_gd_bad++;
        o_sv++;
        s_ack = (o_sv == dly + 1);
        s_rdata = (o_sv == dly + 1) ? rd : 16'($urandom);
      end else begin
        s_ack = 0;
      end
      own_ack = (m == 0) ? m0_ack : m1_ack;
      own_err = (m == 0) ? m0_err : m1_err;
      if (((m == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err)) !== 1'b0) o_other++;
      if (own_ack || own_err) begin
        o_ack = own_ack; o_err = own_err; o_lat = c; o_timeout = 0;
        o_rdata = (m == 0) ? m0_rdata : m1_rdata;
        break;
      end
    end
    set_req(m, 1'b0, '0, '0, 0, 0, 0);
    s_ack = 0;
    @(negedge clk30);
    o_after = (m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (all_outs() !== '0 || s_addr !== '0) begin
      failures++; $display("FAIL reset_outs: got %h exp 0", all_outs());
    end
    repeat (3) @(negedge clk30);
    reset_n = 1'b1;
    @(negedge clk30);
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL idle_outs: got %h exp 0", all_outs());
    end
  endtask

  task automatic test_cdic_read();
    run_access(0, 24'h300004, 16'h0, 0, 1, 1, 3, 16'h1234);
    checks++;
    if (o_ack !== 1 || o_err !== 0 || o_rdata !== 16'h1234) begin
      failures++; $display("FAIL cdic_ack: got ack=%b err=%b rdata=%h exp 1 0 1234", o_ack, o_err, o_rdata);
    end
    checks++;
    if (o_lat != 5 || o_sv != 4 || o_after !== 0) begin
      failures++; $display("FAIL cdic_timing: got lat=%0d sv=%0d after=%b exp 5 4 0", o_lat, o_sv, o_after);
    end
    checks++;
    if (o_region !== REG_CDIC || o_addr !== 23'h180002) begin
      failures++; $display("FAIL cdic_port: got region=%0d addr=%h exp 3 180002", o_region, o_addr);
    end
  endtask

  task automatic test_no_wait();
    run_access(0, 24'h600000, 16'h0, 0, 1, 1, 0, 16'hFFFF);
    checks++;
    if (o_err !== 1 || o_ack !== 0 || o_lat != 1 || o_sv != 0) begin
      failures++; $display("FAIL buserr: got err=%b ack=%b lat=%0d sv=%0d exp 1 0 1 0", o_err, o_ack, o_lat, o_sv);
    end
    run_access(0, 24'h2A0000, 16'h0, 0, 1, 1, 0, 16'hFFFF);
    checks++;
    if (o_ack !== 1 || o_err !== 0 || o_lat != 1 || o_sv != 0 || o_rdata !== 16'h0) begin
      failures++; $display("FAIL none_region: got ack=%b err=%b lat=%0d sv=%0d rdata=%h exp 1 0 1 0 0000",
                           o_ack, o_err, o_lat, o_sv, o_rdata);
    end
  endtask

  task automatic test_random_decode();
    logic [23:0] anchors [10];
    anchors = '{24'h000000, 24'h270000, 24'h280000, 24'h300000, 24'h310000,
                24'h320000, 24'h4F0000, 24'hCF0000, 24'hE70000, 24'hF00000};
    for (int i = 0; i < 40; i++) begin
      int m, dly;
      logic [23:0] ba;
      logic [15:0] d, rd;
      logic w, u, l;
      region_t er;
      m = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) ba = 24'($urandom);
      else ba = anchors[$urandom_range(0, 9)] + 24'($urandom_range(0, 'h1FFFF));
      ba[0] = 1'b0;
      d = 16'($urandom); rd = 16'($urandom); w = 1'($urandom);
      u = 1'($urandom); l = 1'($urandom);
      if ($urandom_range(0, 3) != 0 && !u && !l) u = 1;
      dly = $urandom_range(0, 5);
      er = ref_region(ba);
      run_access(m, ba, d, w, u, l, dly, rd);
      checks++;
      if (o_timeout || o_other != 0 || o_after !== 0) begin
        failures++; $display("FAIL rnd_handshake[%0d]: got timeout=%b other=%0d after=%b exp 0 0 0",
                             i, o_timeout, o_other, o_after);
      end
      if (er == REG_BUSERR || (!u && !l)) begin
        checks++;
        if (o_err !== 1 || o_ack !== 0 || o_lat != 1 || o_sv != 0) begin
          failures++; $display("FAIL rnd_err[%0d] a=%h: got err=%b ack=%b lat=%0d exp 1 0 1", i, ba, o_err, o_ack, o_lat);
        end
      end else if (er == REG_NONE) begin
        checks++;
        if (o_ack !== 1 || o_lat != 1 || o_sv != 0 || o_rdata !== 16'h0) begin
          failures++; $display("FAIL rnd_none[%0d] a=%h: got ack=%b lat=%0d rdata=%h exp 1 1 0000", i, ba, o_ack, o_lat, o_rdata);
        end
      end else begin
        checks++;
        if (o_ack !== 1 || o_err !== 0 || o_lat != dly + 2 || o_sv != dly + 1 || o_rdata !== rd) begin
          failures++; $display("FAIL rnd_acc[%0d] a=%h: got ack=%b lat=%0d sv=%0d rdata=%h exp 1 %0d %0d %h",
                               i, ba, o_ack, o_lat, o_sv, o_rdata, dly + 2, dly + 1, rd);
        end
        checks++;
        if (o_region !== er || o_addr !== ba[23:1] || o_wdata !== d || o_write !== w ||
            o_uds !== u || o_lds !== l || o_gd_bad != 0) begin
          failures++; $display("FAIL rnd_port[%0d]: got reg=%0d addr=%h wd=%h w=%b u=%b l=%b gdbad=%0d exp %0d %h %h %b %b %b 0",
                               i, o_region, o_addr, o_wdata, o_write, o_uds, o_lds, o_gd_bad, er, ba[23:1], d, w, u, l);
        end
      end
    end
  endtask

  // Both masters hammer the bus; every (BM+1)-th grant must go to the CPU.
  task automatic test_burst_fairness();
    int n;
    logic drop0, drop1, last_gd;
    @(negedge clk30);
    set_req(0, 1'b1, 24'h310000 >> 1, 16'hA0A0, 0, 1, 1);
    set_req(1, 1'b1, 24'h300000 >> 1, 16'hB1B1, 0, 1, 1);
    n = 0; drop0 = 0; drop1 = 0; last_gd = 0;
    for (int c = 0; c < 2000 && n < 2 * (BM + 1); c++) begin
      @(negedge clk30);
      if (drop0) m0_req = 1;
      if (drop1) m1_req = 1;
      drop0 = 0; drop1 = 0;
      if (s_valid) begin last_gd = grant_dma; s_ack = 1; end
      else s_ack = 0;
      if (m0_ack || m1_ack) begin
        logic exp_m1;
        exp_m1 = ((n % (BM + 1)) != BM);
        checks++;
        if (m1_ack !== exp_m1 || m0_ack !== !exp_m1 || last_gd !== exp_m1) begin
          failures++; $display("FAIL burst_order[%0d]: got m0=%b m1=%b gd=%b exp m1=%b gd=%b",
                               n, m0_ack, m1_ack, last_gd, exp_m1, exp_m1);
        end
        if (m0_ack) begin m0_req = 0; drop0 = 1; end
        if (m1_ack) begin m1_req = 0; drop1 = 1; end
        n++;
      end
    end
    checks++;
    if (n != 2 * (BM + 1)) begin
      failures++; $display("FAIL burst_count: got %0d grants exp %0d", n, 2 * (BM + 1));
    end
    m0_req = 0; m1_req = 0; s_ack = 0;
    repeat (3) @(negedge clk30);
  endtask

  task automatic test_timeout();
    run_access(1, 24'h300100, 16'h0, 0, 1, 1, 1000, 16'h5555);
    checks++;
    if (o_err !== 1 || o_ack !== 0 || o_sv != TO || o_lat != TO + 1 || o_after !== 0) begin
      failures++; $display("FAIL timeout_err: got err=%b ack=%b sv=%0d lat=%0d exp 1 0 %0d %0d",
                           o_err, o_ack, o_sv, o_lat, TO, TO + 1);
    end
    run_access(1, 24'h300100, 16'h0, 0, 1, 1, TO - 1, 16'h5A5A);
    checks++;
    if (o_ack !== 1 || o_err !== 0 || o_sv != TO || o_lat != TO + 1 || o_rdata !== 16'h5A5A) begin
      failures++; $display("FAIL timeout_lastack: got ack=%b err=%b sv=%0d lat=%0d rdata=%h exp 1 0 %0d %0d 5a5a",
                           o_ack, o_err, o_sv, o_lat, o_rdata, TO, TO + 1);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen, stray;
    logic [15:0] d;
    @(negedge clk30);
    set_req(0, 1'b1, 24'h300010 >> 1, 16'h0, 0, 1, 1);
    seen = 0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      @(negedge clk30);
      if (s_valid) seen++;
    end
    checks++;
    if (seen != 2) begin
      failures++; $display("FAIL rst_enter_wait: got %0d valid cycles exp 2", seen);
    end
    reset_n = 0;
    #1;
    checks++;
    if (all_outs() !== '0 || s_addr !== '0) begin
      failures++; $display("FAIL rst_mid_outs: got %h exp 0", all_outs());
    end
    stray = 0;
    m0_req = 0;
    repeat (2) @(negedge clk30);
    reset_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk30);
      if (m0_ack || m0_err || m1_ack || m1_err || s_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL rst_stray: got %0d active cycles exp 0", stray);
    end
    d = 16'($urandom);
    run_access(1, 24'h320010, d, 1, 1, 0, 2, 16'h0);
    checks++;
    if (o_ack !== 1 || o_err !== 0 || o_region !== REG_MK48 || o_write !== 1 || o_uds !== 1 ||
        o_lds !== 0 || o_wdata !== d || o_addr !== 23'h190008 || o_gd_bad != 0 || o_lat != 4) begin
      failures++; $display("FAIL post_rst_write: got ack=%b reg=%0d w=%b u=%b l=%b wd=%h addr=%h gdbad=%0d lat=%0d exp 1 5 1 1 0 %h 190008 0 4",
                           o_ack, o_region, o_write, o_uds, o_lds, o_wdata, o_addr, o_gd_bad, o_lat, d);
    end
  endtask

  initial begin
    test_reset();
    test_cdic_read();
    test_no_wait();
    test_random_decode();
    test_burst_fairness();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
